// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multicycle control path: opcodes, instruction classes,
// FSM states and AluOp encodings.
package legv8_pkg;

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [7:0]  OpCbzHi = 8'b10110100;
    localparam logic [5:0]  OpBHi   = 6'b000101;

    typedef enum logic [1:0] {
        AluOpMem   = 2'b00,
        AluOpCbz   = 2'b01,
        AluOpRtype = 2'b10
    } aluop_e;

    typedef enum logic [2:0] {
        ClsNone,
        ClsRtype,
        ClsLdur,
        ClsStur,
        ClsCbz,
        ClsB,
        ClsIllegal
    } instr_class_e;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StFault
    } state_e;

    function automatic instr_class_e decode_class(input logic [10:0] op);
        instr_class_e cls;
        if (op == OpAdd || op == OpSub || op == OpAnd || op == OpOrr) begin
            cls = ClsRtype;
        end else if (op == OpLdur) begin
            cls = ClsLdur;
        end else if (op == OpStur) begin
            cls = ClsStur;
        end else if (op[10:3] == OpCbzHi) begin
            cls = ClsCbz;
        end else if (op[10:5] == OpBHi) begin
            cls = ClsB;
        end else begin
            cls = ClsIllegal;
        end
        return cls;
    endfunction

endpackage

// File: rtl/legv8_mc_control_if.sv
// Instruction/data memory handshake between the control FSM (master) and the memories (slave).
interface legv8_mc_control_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemRead;
    logic MemWrite;

    modport master (
        output imem_req,
        output dmem_req,
        output MemRead,
        output MemWrite,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  MemRead,
        input  MemWrite,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/legv8_mc_control.sv
// Multicycle main control FSM for the LEGv8 core: sequences fetch/decode/execute/memory/
// writeback, drives datapath strobes and AluOp, and raises a sticky fault.
module legv8_mc_control
    import legv8_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                opcode,
    input  logic                       zero,
    legv8_mc_control_if.master         mem,
    output logic                       IrWrite,
    output logic                       PcWrite,
    output logic                       PcSrc,
    output logic                       Reg2Loc,
    output logic                       AluSrc,
    output logic [1:0]                 AluOp,
    output logic                       MemtoReg,
    output logic                       RegWrite,
    output logic                       retire,
    output logic                       fault
);

    localparam logic [CNT_W-1:0] WaitLimit = CNT_W'(WAIT_MAX);

    state_e             state_q, state_d;
    instr_class_e       cls_q, cls_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        // Counter only survives while a request keeps waiting; every other path clears it.
        cnt_d        = '0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        IrWrite      = 1'b0;
        PcWrite      = 1'b0;
        PcSrc        = 1'b0;
        Reg2Loc      = 1'b0;
        AluSrc       = 1'b0;
        AluOp        = AluOpMem;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        retire       = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    IrWrite = 1'b1;
                    PcWrite = 1'b1;
                    state_d = StDecode;
                end else if (cnt_q == WaitLimit) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDecode: begin
                cls_d   = decode_class(opcode);
                state_d = (cls_d == ClsIllegal) ? StFault : StExec;
            end

            StExec: begin
                unique case (cls_q)
                    ClsRtype: begin
                        AluOp   = AluOpRtype;
                        state_d = StWb;
                    end
                    ClsLdur, ClsStur: begin
                        AluOp   = AluOpMem;
                        AluSrc  = 1'b1;
                        Reg2Loc = 1'b1;
                        state_d = StMem;
                    end
                    ClsCbz: begin
                        AluOp   = AluOpCbz;
                        Reg2Loc = 1'b1;
                        PcWrite = zero;
                        PcSrc   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsB: begin
                        PcWrite = 1'b1;
                        PcSrc   = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StFault;
                endcase
            end

            StMem: begin
                mem.dmem_req = 1'b1;
                mem.MemRead  = (cls_q == ClsLdur);
                mem.MemWrite = (cls_q == ClsStur);
                AluOp        = AluOpMem;
                AluSrc       = 1'b1;
                if (mem.dmem_ready) begin
                    if (cls_q == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (cnt_q == WaitLimit) begin
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWb: begin
                RegWrite = 1'b1;
                MemtoReg = (cls_q == ClsLdur);
                // Keep the EXEC operand selection so the ALU result stays stable for writeback.
                if (cls_q == ClsLdur) begin
                    AluOp  = AluOpMem;
                    AluSrc = 1'b1;
                end else begin
                    AluOp  = AluOpRtype;
                end
                retire  = 1'b1;
                state_d = StFetch;
            end

            StFault: begin
                fault = 1'b1;
            end

            default: state_d = StFault;
        endcase
    end

endmodule

// File: tb/tb_legv8_mc_control.sv
// Bench for legv8_mc_control: a per-instruction trace model expands each directed instruction
// into expected per-cycle inputs and outputs, replayed and compared cycle by cycle.
module tb_legv8_mc_control;

    localparam int WAIT_MAX = 16;

    // Bit positions in the packed output vector.
    localparam int O_IREQ = 14, O_DREQ = 13, O_MRD = 12, O_MWR = 11, O_IRW = 10, O_PCW = 9;
    localparam int O_PCS = 8, O_R2L = 7, O_ASRC = 6, O_M2R = 3, O_RW = 2, O_RET = 1, O_FLT = 0;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic        ir;
        logic        dr;
        logic [14:0] out;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        IrWrite, PcWrite, PcSrc, Reg2Loc, AluSrc, MemtoReg, RegWrite, retire, fault;
    logic [1:0]  AluOp;
    logic [14:0] outs;

    cyc_t  exp_q[$];
    string cur_test = "";
    int    checks = 0;
    int    errors = 0;

    legv8_mc_control_if mif ();

    legv8_mc_control dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .zero     (zero),
        .mem      (mif),
        .IrWrite  (IrWrite),
        .PcWrite  (PcWrite),
        .PcSrc    (PcSrc),
        .Reg2Loc  (Reg2Loc),
        .AluSrc   (AluSrc),
        .AluOp    (AluOp),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .retire   (retire),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    assign outs = {mif.imem_req, mif.dmem_req, mif.MemRead, mif.MemWrite, IrWrite, PcWrite,
                   PcSrc, Reg2Loc, AluSrc, AluOp, MemtoReg, RegWrite, retire, fault};

    task automatic check(input string nm, input logic [14:0] got, input logic [14:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic int classify(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return K_R;
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (hi8 == 8'b10110100) return K_CBZ;
        if (hi6 == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    task automatic push(input logic [10:0] op, input logic z, input logic ir, input logic dr,
                        input logic [14:0] o);
        cyc_t c;
        c.op = op; c.z = z; c.ir = ir; c.dr = dr; c.out = o;
        exp_q.push_back(c);
    endtask

    task automatic add_fault(input logic [10:0] op, input int n);
        logic [14:0] o;
        o = '0;
        o[O_FLT] = 1'b1;
        for (int i = 0; i < n; i++) push(op, 1'b0, 1'b0, 1'b0, o);
    endtask

    // iw/dw: memory wait cycles before ready; more than WAIT_MAX means the access times out.
    task automatic add_instr(input logic [10:0] op, input logic z, input int iw, input int dw);
        logic [14:0] o;
        int k;
        k = classify(op);
        o = '0;
        o[O_IREQ] = 1'b1;
        for (int i = 0; i < iw && i <= WAIT_MAX; i++) push(op, z, 1'b0, 1'b0, o);
        if (iw > WAIT_MAX) begin
            add_fault(op, 4);
            return;
        end
        o[O_IRW] = 1'b1;
        o[O_PCW] = 1'b1;
        push(op, z, 1'b1, 1'b0, o);
        push(op, z, 1'b0, 1'b0, 15'h0);
        o = '0;
        case (k)
            K_R: begin
                o[5:4] = 2'b10;
                push(op, z, 1'b0, 1'b0, o);
                o[O_RW] = 1'b1;
                o[O_RET] = 1'b1;
                push(op, z, 1'b0, 1'b0, o);
            end
            K_LD, K_ST: begin
                o[O_ASRC] = 1'b1;
                o[O_R2L] = 1'b1;
                push(op, z, 1'b0, 1'b0, o);
                o = '0;
                o[O_DREQ] = 1'b1;
                o[O_ASRC] = 1'b1;
                if (k == K_LD) o[O_MRD] = 1'b1;
                else o[O_MWR] = 1'b1;
                for (int i = 0; i < dw && i <= WAIT_MAX; i++) push(op, z, 1'b0, 1'b0, o);
                if (dw > WAIT_MAX) begin
                    add_fault(op, 4);
                    return;
                end
                if (k == K_ST) o[O_RET] = 1'b1;
                push(op, z, 1'b0, 1'b1, o);
                if (k == K_LD) begin
                    o = '0;
                    o[O_ASRC] = 1'b1;
                    o[O_M2R] = 1'b1;
                    o[O_RW] = 1'b1;
                    o[O_RET] = 1'b1;
                    push(op, z, 1'b0, 1'b0, o);
                end
            end
            K_CBZ: begin
                o[5:4] = 2'b01;
                o[O_R2L] = 1'b1;
                o[O_PCW] = z;
                o[O_PCS] = 1'b1;
                o[O_RET] = 1'b1;
                push(op, z, 1'b0, 1'b0, o);
            end
            K_B: begin
                o[O_PCW] = 1'b1;
                o[O_PCS] = 1'b1;
                o[O_RET] = 1'b1;
                push(op, z, 1'b0, 1'b0, o);
            end
            default: add_fault(op, 20);
        endcase
    endtask

    // Entered at posedge+1 with rst low; leaves at posedge+1 after the last replayed cycle.
    task automatic play(input int max_n);
        cyc_t c;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_n) begin
            c = exp_q.pop_front();
            opcode = c.op;
            zero = c.z;
            mif.imem_ready = c.ir;
            mif.dmem_ready = c.dr;
            @(negedge clk);
            check($sformatf("%s cyc %0d", cur_test, n), outs, c.out);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset(input string nm);
        cur_test = nm;
        exp_q.delete();
        rst = 1'b1;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        check({nm, " reset"}, outs, 15'h4000);
        rst = 1'b0;
    endtask

    initial begin
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;

        do_reset("add");
        add_instr(11'b10001011000, 1'b0, 0, 0);
        check_int("add len", exp_q.size(), 4);
        check("add fetch pin", exp_q[0].out, 15'h4600);
        check("add exec pin", exp_q[2].out, 15'h0020);
        check("add wb pin", exp_q[3].out, 15'h0026);
        play(1000);

        do_reset("ldur");
        add_instr(11'b11111000010, 1'b0, 0, 3);
        check_int("ldur len", exp_q.size(), 8);
        check("ldur mem pin", exp_q[3].out, 15'h3040);
        check("ldur wb pin", exp_q[7].out, 15'h004E);
        play(1000);

        do_reset("cbz");
        add_instr(11'b10110100101, 1'b1, 0, 0);
        add_instr(11'b10110100000, 1'b0, 1, 0);
        check_int("cbz len", exp_q.size(), 7);
        check("cbz taken pin", exp_q[2].out, 15'h0392);
        check("cbz not taken pin", exp_q[6].out, 15'h0192);
        play(1000);

        do_reset("program");
        add_instr(11'b11001011000, 1'b0, 2, 0);
        add_instr(11'b10001010000, 1'b1, 0, 0);
        add_instr(11'b10101010000, 1'b0, 0, 0);
        add_instr(11'b11111000000, 1'b0, 0, 0);
        add_instr(11'b11111000000, 1'b0, 1, 5);
        add_instr(11'b00010110011, 1'b0, 0, 0);
        add_instr(11'b11111000010, 1'b1, 3, 16);
        add_instr(11'b10001011000, 1'b0, 0, 0);
        play(1000);

        do_reset("illegal");
        add_instr(11'h000, 1'b0, 0, 0);
        check_int("illegal len", exp_q.size(), 22);
        play(1000);

        do_reset("near ldur");
        add_instr(11'b11111000011, 1'b0, 0, 0);
        play(1000);

        do_reset("imem timeout");
        add_instr(11'b10001011000, 1'b0, 17, 0);
        check_int("imem timeout len", exp_q.size(), 21);
        play(1000);

        do_reset("imem at limit");
        add_instr(11'b10001011000, 1'b0, 16, 0);
        check_int("imem at limit len", exp_q.size(), 20);
        play(1000);

        do_reset("dmem timeout");
        add_instr(11'b11111000010, 1'b0, 0, 20);
        play(1000);

        do_reset("rst mid mem");
        add_instr(11'b11111000000, 1'b0, 0, 10);
        play(5);
        check("stur waiting in mem", outs, 15'h2840);
        rst = 1'b1;
        #1;
        check("stur async reset", outs, 15'h4000);
        exp_q.delete();

        do_reset("after reset");
        add_instr(11'b00010100000, 1'b0, 0, 0);
        play(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
